// File: rtl/ikaopll_frame_mixer.sv
// ikaopll_frame_mixer
//   Collects the time-multiplexed MO (melody) and RO (rhythm) samples of the
//   IKAOPLL core over one sample frame. At each frame sync it latches the frame
//   sums. One enabled cycle later it presents a gain-weighted mono PCM word,
//   saturated to OUT_WIDTH bits.
//
// Ports
//   i_EMUCLK        master clock
//   i_IC_n          asynchronous active-low reset
//   i_phiM_PCEN_n   clock enable, active low; all state holds while high
//   i_FRAME_SYNC    frame boundary tick (one enabled cycle)
//   i_MO_SAMPLE     MO sample strobe
//   i_MO            signed 10-bit MO sample
//   i_RO_SAMPLE     RO sample strobe
//   i_RO            signed 10-bit RO sample
//   o_MO_ACC        latched MO frame sum (signed 14-bit)
//   o_RO_ACC        latched RO frame sum (signed 14-bit)
//   o_MO_CNT        MO strobes accepted in latched frame
//   o_RO_CNT        RO strobes accepted in latched frame
//   o_MIX           saturated mix word
//   o_MIX_VALID     o_MIX refreshed, high for one enabled cycle
//   o_CLIP          o_MIX was saturated (qualified by o_MIX_VALID)
//   o_OVERRUN       sticky: dropped strobe or sync while a mix was pending
//
// FSM states
//   state     | meaning
//   WAIT_SYNC | after reset; strobes ignored until the first sync arms the block
//   ACCUM     | accumulating the current frame
//   MIX       | mix of the latched frame computed this cycle; still accumulating

module ikaopll_frame_mixer #(
    parameter int MO_GAIN_SHIFT = 0,
    parameter int RO_GAIN_SHIFT = 1,
    parameter int OUT_WIDTH     = 16
) (
    input  logic                        i_EMUCLK,
    input  logic                        i_IC_n,
    input  logic                        i_phiM_PCEN_n,
    input  logic                        i_FRAME_SYNC,
    input  logic                        i_MO_SAMPLE,
    input  logic signed [9:0]           i_MO,
    input  logic                        i_RO_SAMPLE,
    input  logic signed [9:0]           i_RO,
    output logic signed [13:0]          o_MO_ACC,
    output logic signed [13:0]          o_RO_ACC,
    output logic [3:0]                  o_MO_CNT,
    output logic [3:0]                  o_RO_CNT,
    output logic signed [OUT_WIDTH-1:0] o_MIX,
    output logic                        o_MIX_VALID,
    output logic                        o_CLIP,
    output logic                        o_OVERRUN
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACCUM     = 2'd1,
        MIX       = 2'd2
    } state_t;

    localparam int SUM_W = 17;
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_WIDTH - 1));

    state_t state_q;
    state_t state_d;

    logic en;
    logic arm;
    logic latch;
    logic accum_en;
    logic mix_en;
    logic resync_err;

    logic signed [13:0] mo_run;
    logic signed [13:0] ro_run;
    logic [3:0]         mo_cnt_run;
    logic [3:0]         ro_cnt_run;
    logic signed [13:0] mo_ext;
    logic signed [13:0] ro_ext;
    logic               mo_drop;
    logic               ro_drop;

    logic signed [SUM_W-1:0]     mo_term;
    logic signed [SUM_W-1:0]     ro_term;
    logic signed [SUM_W-1:0]     mix_sum;
    logic signed [31:0]          sum_wide;
    logic signed [OUT_WIDTH-1:0] mix_sat;
    logic                        mix_clip;

    assign en     = ~i_phiM_PCEN_n;
    assign mo_ext = {{4{i_MO[9]}}, i_MO};
    assign ro_ext = {{4{i_RO[9]}}, i_RO};

    // A strobe on a sync cycle starts the new frame, so it can never overflow
    // the (just reloaded) count; only mid-frame strobes at 15 are dropped.
    assign mo_drop = accum_en & ~latch & i_MO_SAMPLE & (mo_cnt_run == 4'd15);
    assign ro_drop = accum_en & ~latch & i_RO_SAMPLE & (ro_cnt_run == 4'd15);

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            state_q <= WAIT_SYNC;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        arm        = 1'b0;
        latch      = 1'b0;
        accum_en   = 1'b0;
        mix_en     = 1'b0;
        resync_err = 1'b0;
        case (state_q)
            WAIT_SYNC: begin
                if (i_FRAME_SYNC) begin
                    arm     = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                accum_en = 1'b1;
                if (i_FRAME_SYNC) begin
                    latch   = 1'b1;
                    state_d = MIX;
                end
            end
            MIX: begin
                accum_en = 1'b1;
                mix_en   = 1'b1;
                if (i_FRAME_SYNC) begin
                    // Back-to-back sync: the pending mix is still produced,
                    // the new frame is latched and mixed next cycle.
                    latch      = 1'b1;
                    resync_err = 1'b1;
                end else begin
                    state_d = ACCUM;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            mo_run     <= '0;
            ro_run     <= '0;
            mo_cnt_run <= '0;
            ro_cnt_run <= '0;
        end else if (en) begin
            if (arm || latch) begin
                mo_run     <= i_MO_SAMPLE ? mo_ext : 14'sd0;
                ro_run     <= i_RO_SAMPLE ? ro_ext : 14'sd0;
                mo_cnt_run <= {3'd0, i_MO_SAMPLE};
                ro_cnt_run <= {3'd0, i_RO_SAMPLE};
            end else if (accum_en) begin
                if (i_MO_SAMPLE && (mo_cnt_run != 4'd15)) begin
                    mo_run     <= mo_run + mo_ext;
                    mo_cnt_run <= mo_cnt_run + 4'd1;
                end
                if (i_RO_SAMPLE && (ro_cnt_run != 4'd15)) begin
                    ro_run     <= ro_run + ro_ext;
                    ro_cnt_run <= ro_cnt_run + 4'd1;
                end
            end
        end
    end

    // Mix is formed from the latched sums, which are stable for the MIX cycle.
    assign mo_term  = {{3{o_MO_ACC[13]}}, o_MO_ACC} <<< MO_GAIN_SHIFT;
    assign ro_term  = {{3{o_RO_ACC[13]}}, o_RO_ACC} <<< RO_GAIN_SHIFT;
    assign mix_sum  = mo_term + ro_term;
    assign sum_wide = {{(32 - SUM_W){mix_sum[SUM_W-1]}}, mix_sum};

    always_comb begin
        mix_clip = 1'b0;
        mix_sat  = sum_wide[OUT_WIDTH-1:0];
        if (sum_wide > SAT_MAX) begin
            mix_sat  = SAT_MAX[OUT_WIDTH-1:0];
            mix_clip = 1'b1;
        end else if (sum_wide < SAT_MIN) begin
            mix_sat  = SAT_MIN[OUT_WIDTH-1:0];
            mix_clip = 1'b1;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            o_MO_ACC    <= '0;
            o_RO_ACC    <= '0;
            o_MO_CNT    <= '0;
            o_RO_CNT    <= '0;
            o_MIX       <= '0;
            o_MIX_VALID <= 1'b0;
            o_CLIP      <= 1'b0;
            o_OVERRUN   <= 1'b0;
        end else if (en) begin
            if (latch) begin
                o_MO_ACC <= mo_run;
                o_RO_ACC <= ro_run;
                o_MO_CNT <= mo_cnt_run;
                o_RO_CNT <= ro_cnt_run;
            end
            o_MIX_VALID <= mix_en;
            if (mix_en) begin
                o_MIX  <= mix_sat;
                o_CLIP <= mix_clip;
            end
            if (resync_err || mo_drop || ro_drop) begin
                o_OVERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ikaopll_frame_mixer.md
# ikaopll_frame_mixer

Per-frame output accumulator sitting directly downstream of the IKAOPLL core outputs. It collects the time-multiplexed signed 10-bit melody (MO) and rhythm (RO) channel samples, qualified by their sample strobes, over one sample frame delimited by a frame-sync tick. At each frame boundary it latches the frame sums and produces one gain-weighted, saturated mono PCM word with a valid flag, for the host audio path.

## Interface
- MO_GAIN_SHIFT, default 0: left shift applied to the latched MO sum before mixing (0..2).
- RO_GAIN_SHIFT, default 1: left shift applied to the latched RO sum before mixing (0..2).
- OUT_WIDTH, default 16: mix output width (12..24).

- i_EMUCLK  in  1  master clock (same as XIN).
- i_IC_n  in  1  reset; one clock, asynchronous, active-low.
- i_phiM_PCEN_n  in  1  clock enable, negative logic; state updates only on i_EMUCLK rising edges with this low.
- i_FRAME_SYNC  in  1  frame boundary tick, high for one enabled cycle.
- i_MO_SAMPLE  in  1  MO sample strobe.
- i_MO  in  10  signed MO sample.
- i_RO_SAMPLE  in  1  RO sample strobe.
- i_RO  in  10  signed RO sample.
- o_MO_ACC  out  14  signed latched MO frame sum.
- o_RO_ACC  out  14  signed latched RO frame sum.
- o_MO_CNT  out  4  MO strobes accepted in latched frame.
- o_RO_CNT  out  4  RO strobes accepted in latched frame.
- o_MIX  out  OUT_WIDTH  signed saturated mix.
- o_MIX_VALID  out  1  new o_MIX, one enable period.
- o_CLIP  out  1  o_MIX was saturated; qualified by o_MIX_VALID.
- o_OVERRUN  out  1  sticky error flag.

## Operation
- Enabled cycle: i_phiM_PCEN_n low at i_EMUCLK rising edge. All inputs sampled only then; disabled cycles hold all state.
- FSM states:
  - WAIT_SYNC: reset state; strobes ignored.
  - ACCUM: accumulating.
  - MIX: computing/presenting the mix.
- Transitions:
  - WAIT_SYNC -> ACCUM on i_FRAME_SYNC; no output, accumulators cleared, any same-cycle strobe loaded as first sample of the new frame.
  - ACCUM -> MIX on i_FRAME_SYNC.
  - MIX -> ACCUM next enabled cycle unless i_FRAME_SYNC is high again.
- Accumulation (ACCUM and MIX): on strobe, running acc += sign-extended sample (14-bit); running count += 1.
  - Count saturates at 15. A strobe arriving at count 15 is dropped and sets o_OVERRUN.
  - 15 x ±512 fits in 14 bits; no accumulator wrap is possible.
- Frame latch on i_FRAME_SYNC (ACCUM or MIX): running acc/count copied to o_*_ACC/o_*_CNT. Running registers are reloaded with the same-cycle strobe sample, or 0 / count 0 if none. A same-cycle strobe belongs to the new frame.
- Mix (computed from latched sums):
  - sum = (o_MO_ACC << MO_GAIN_SHIFT) + (o_RO_ACC << RO_GAIN_SHIFT) at 17 bits.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - o_CLIP = 1 if saturation occurred.
- i_FRAME_SYNC while in MIX: latch the new frame, recompute the mix, stay in MIX, set o_OVERRUN.
- o_OVERRUN clears only on reset.

## Timing
- Reset (async assert, release synchronous to i_EMUCLK): all outputs 0, FSM = WAIT_SYNC, running registers 0.
- Frame latch edge E (enabled, i_FRAME_SYNC=1): o_*_ACC and o_*_CNT update at E.
- o_MIX, o_CLIP, and o_MIX_VALID=1 update at the next enabled edge E+1.
- o_MIX_VALID returns to 0 at the following enabled edge, unless re-armed by a MIX->MIX hold.
- o_MIX holds its value until the next mix.
- Latency from latch edge to valid: 1 enabled cycle.
- Reset mid-frame: partial frame discarded; the first sync after reset only arms the block.

## Test plan
- Reset, sync, then 9 MO strobes of +100 and 5 RO strobes of -50, then sync -> o_MO_ACC=900, o_RO_ACC=-250, counts 9/5, o_MIX=400 one enabled cycle later with o_MIX_VALID=1 and o_CLIP=0.
- OUT_WIDTH=12: 15 MO strobes of +511 -> o_MO_ACC=7665, o_MIX=2047, o_CLIP=1. Repeat with -512 -> o_MIX=-2048, o_CLIP=1.
- 16 MO strobes of +1 in one frame -> o_MO_CNT=15, o_MO_ACC=15, o_OVERRUN=1 and staying 1 across later frames until reset.
- MO strobe +7 coincident with i_FRAME_SYNC -> excluded from the latched frame; the next frame's o_MO_ACC includes 7.
- Hold i_phiM_PCEN_n high for 20 clocks with strobes and sync toggling -> no state change. Assert i_IC_n low mid-frame -> all outputs 0 immediately; first post-reset sync yields no o_MIX_VALID.
